eth_phy_10g_rx_gearbox: RTL and testbench



---
 rtl/eth_phy_10g_rx_gearbox.sv | 125 ++++++++++++
 tb/tb_eth_phy_10g_rx_gearbox.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_phy_10g_rx_gearbox.sv
// 10GBASE-R receive gearbox: raw IN_WIDTH-bit transceiver words in, aligned 66-bit blocks out, with bitslip.
// Optional build macro ETH_RX_GEARBOX_SLIP_COUNT_EN adds a saturating applied-slip counter on rx_slip_count.
module eth_phy_10g_rx_gearbox #(
    parameter int IN_WIDTH    = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int BIT_REVERSE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   serdes_rx_data_in,
    input  logic                  serdes_rx_valid_in,
    input  logic                  serdes_rx_bitslip,
    output logic [DATA_WIDTH-1:0] serdes_rx_data,
    output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    output logic                  serdes_rx_valid,
    output logic [7:0]            rx_slip_count
);

    localparam int BLOCK_WIDTH = 66;
    localparam int BUF_WIDTH   = IN_WIDTH + BLOCK_WIDTH;
    localparam logic [7:0] IN_W8    = 8'(IN_WIDTH);
    localparam logic [7:0] BLOCK_W8 = 8'(BLOCK_WIDTH);

    genvar gi;

    generate
        if (!(IN_WIDTH == 32 || IN_WIDTH == 64)) begin : g_bad_in_width
            $error("eth_phy_10g_rx_gearbox: IN_WIDTH must be 32 or 64");
        end
        if (DATA_WIDTH != 64) begin : g_bad_data_width
            $error("eth_phy_10g_rx_gearbox: DATA_WIDTH must be 64");
        end
        if (HDR_WIDTH != 2) begin : g_bad_hdr_width
            $error("eth_phy_10g_rx_gearbox: HDR_WIDTH must be 2");
        end
    endgenerate

    logic [IN_WIDTH-1:0] word;

    generate
        for (gi = 0; gi < IN_WIDTH; gi++) begin : g_word
            if (BIT_REVERSE != 0) begin : g_rev
                assign word[gi] = serdes_rx_data_in[IN_WIDTH-1-gi];
            end else begin : g_fwd
                assign word[gi] = serdes_rx_data_in[gi];
            end
        end
    endgenerate

    logic [BUF_WIDTH-1:0] bit_buf_reg, bit_buf_next, buf_app;
    logic [7:0]           cnt_reg, cnt_next, cnt_app;
    logic                 slip_pend_reg, slip_pend_next;
    logic                 slip_applied;
    logic                 extract;

    always_comb begin
        buf_app        = bit_buf_reg;
        cnt_app        = cnt_reg;
        slip_pend_next = slip_pend_reg;
        slip_applied   = 1'b0;
        if (serdes_rx_valid_in) begin
            // Part-select write so stale bits above cnt are overwritten, never merged.
            buf_app[cnt_reg +: IN_WIDTH] = word;
            cnt_app = cnt_reg + IN_W8;
            if (serdes_rx_bitslip || slip_pend_reg) begin
                buf_app        = buf_app >> 1;
                cnt_app        = cnt_app - 8'd1;
                slip_pend_next = 1'b0;
                slip_applied   = 1'b1;
            end
        end else if (serdes_rx_bitslip) begin
            slip_pend_next = 1'b1;
        end

        extract = (cnt_app >= BLOCK_W8);
        if (extract) begin
            bit_buf_next = buf_app >> BLOCK_WIDTH;
            cnt_next     = cnt_app - BLOCK_W8;
        end else begin
            bit_buf_next = buf_app;
            cnt_next     = cnt_app;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_buf_reg     <= '0;
            cnt_reg         <= '0;
            slip_pend_reg   <= 1'b0;
            serdes_rx_data  <= '0;
            serdes_rx_hdr   <= '0;
            serdes_rx_valid <= 1'b0;
        end else begin
            bit_buf_reg     <= bit_buf_next;
            cnt_reg         <= cnt_next;
            slip_pend_reg   <= slip_pend_next;
            serdes_rx_valid <= extract;
            if (extract) begin
                serdes_rx_hdr  <= buf_app[HDR_WIDTH-1:0];
                serdes_rx_data <= buf_app[HDR_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef ETH_RX_GEARBOX_SLIP_COUNT_EN
    logic [7:0] slip_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            slip_count_reg <= 8'd0;
        end else if (slip_applied && (slip_count_reg != 8'hFF)) begin
            slip_count_reg <= slip_count_reg + 8'd1;
        end
    end

    assign rx_slip_count = slip_count_reg;
`else
    logic slip_applied_unused;

    assign slip_applied_unused = slip_applied;
    assign rx_slip_count       = 8'd0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_gearbox.sv
// Randomised and directed bench for eth_phy_10g_rx_gearbox against a bit-queue reference model.
// A second instance covers IN_WIDTH=64 with BIT_REVERSE=1.
module tb_eth_phy_10g_rx_gearbox;

    localparam logic [1:0]  HDR_PAT  = 2'b01;
    localparam logic [63:0] DATA_PAT = 64'h0123456789ABCDEF;
`ifdef ETH_RX_GEARBOX_SLIP_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] din32 = '0;
    logic        vin32 = 1'b0;
    logic        slip32 = 1'b0;
    logic [63:0] data32;
    logic [1:0]  hdr32;
    logic        valid32;
    logic [7:0]  cnt32;

    logic [63:0] din64 = '0;
    logic        vin64 = 1'b0;
    logic        slip64 = 1'b0;
    logic [63:0] data64;
    logic [1:0]  hdr64;
    logic        valid64;
    logic [7:0]  cnt64;

    eth_phy_10g_rx_gearbox #(.IN_WIDTH(32), .BIT_REVERSE(0)) dut (
        .clk(clk), .rst(rst),
        .serdes_rx_data_in(din32), .serdes_rx_valid_in(vin32), .serdes_rx_bitslip(slip32),
        .serdes_rx_data(data32), .serdes_rx_hdr(hdr32), .serdes_rx_valid(valid32),
        .rx_slip_count(cnt32)
    );

    eth_phy_10g_rx_gearbox #(.IN_WIDTH(64), .BIT_REVERSE(1)) dut64 (
        .clk(clk), .rst(rst),
        .serdes_rx_data_in(din64), .serdes_rx_valid_in(vin64), .serdes_rx_bitslip(slip64),
        .serdes_rx_data(data64), .serdes_rx_hdr(hdr64), .serdes_rx_valid(valid64),
        .rx_slip_count(cnt64)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of received bits; the head is the oldest bit.
    bit          mq[$];
    bit          mpend;
    int          mslips;
    logic        mvalid;
    logic [1:0]  mhdr;
    logic [63:0] mdata;

    int          strobes;
    int          word_no;
    int          first_word;
    logic [1:0]  first_hdr;
    bit          want_aligned;

    function automatic bit sbit(input int p, input int off);
        int b;
        if (p < off) return 1'b0;
        b = (p - off) % 66;
        return (b < 2) ? HDR_PAT[b] : DATA_PAT[b-2];
    endfunction

    function automatic logic [31:0] stream_word(input int base, input int off);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = sbit(base + i, off);
        return w;
    endfunction

    task automatic model_clear();
        mq.delete();
        mpend  = 1'b0;
        mslips = 0;
        mvalid = 1'b0;
        mhdr   = '0;
        mdata  = '0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] w, input logic s);
        if (v) begin
            for (int i = 0; i < 32; i++) mq.push_back(w[i]);
            if (s || mpend) begin
                void'(mq.pop_front());
                mpend = 1'b0;
                if (mslips < 255) mslips++;
            end
        end else if (s) begin
            mpend = 1'b1;
        end
        if (mq.size() >= 66) begin
            mvalid = 1'b1;
            mhdr   = {mq[1], mq[0]};
            for (int i = 0; i < 64; i++) mdata[i] = mq[i+2];
            for (int i = 0; i < 66; i++) void'(mq.pop_front());
        end else begin
            mvalid = 1'b0;
        end
    endtask

    task automatic drive32(input logic v, input logic [31:0] w, input logic s);
        din32  = w;
        vin32  = v;
        slip32 = s;
        model_step(v, w, s);
        @(posedge clk);
        #1;
        if (v) word_no++;
        $display("txn word=%0d vin=%0b slip=%0b -> valid=%0b hdr=%b data=%h cnt=%0d",
                 word_no, v, s, valid32, hdr32, data32, cnt32);
        check("valid", 64'(valid32), 64'(mvalid));
        check("hdr", 64'(hdr32), 64'(mhdr));
        check("data", data32, mdata);
        check("slip_count", 64'(cnt32), CNT_EN ? 64'(mslips) : 64'd0);
        if (valid32) begin
            strobes++;
            if (first_word == 0) begin
                first_word = word_no;
                first_hdr  = hdr32;
            end
            if (want_aligned) begin
                check("aligned_hdr", 64'(hdr32), 64'(HDR_PAT));
                check("aligned_data", data32, DATA_PAT);
            end
        end
        slip32 = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        vin32 = 1'b0;
        vin64 = 1'b0;
        slip32 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("txn reset -> valid=%0b hdr=%b data=%h cnt=%0d valid64=%0b",
                 valid32, hdr32, data32, cnt32, valid64);
        check("rst_valid", 64'(valid32), 64'd0);
        check("rst_hdr", 64'(hdr32), 64'd0);
        check("rst_data", data32, 64'd0);
        check("rst_slip_count", 64'(cnt32), 64'd0);
        check("rst_valid64", 64'(valid64), 64'd0);
        model_clear();
        strobes      = 0;
        word_no      = 0;
        first_word   = 0;
        want_aligned = 1'b0;
    endtask

    initial begin
        int pos;
        int n_prev;
        int n_cur;
        logic exp_v;
        logic [63:0] w64;

        do_reset();

        // Basic alignment: 33 words carry exactly 16 blocks.
        want_aligned = 1'b1;
        pos = 0;
        for (int i = 0; i < 33; i++) begin
            drive32(1'b1, stream_word(pos, 0), 1'b0);
            pos += 32;
        end
        check("basic_first_word", 64'(first_word), 64'd3);
        check("basic_strobes", 64'(strobes), 64'd16);

        // Bitslip acquisition with one leading garbage bit.
        do_reset();
        pos = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) want_aligned = 1'b1;
            drive32(1'b1, stream_word(pos, 1), i == 4);
            pos += 32;
        end
        check("acq_first_hdr", 64'(first_hdr), 64'(2'b10));
        check("acq_first_word", 64'(first_word), 64'd3);

        // Input gaps, with two slip requests in consecutive gaps collapsing into one.
        do_reset();
        want_aligned = 1'b1;
        pos = 0;
        for (int i = 0; i < 64; i++) begin
            if (i == 2 || i % 4 == 3) begin
                drive32(1'b0, $urandom, (i == 2 || i == 3));
            end else begin
                drive32(1'b1, stream_word(pos, 1), 1'b0);
                pos += 32;
            end
        end
        check("gap_strobes", 64'(strobes), 64'(((pos - 1) / 66)));

        // Reset mid-block once 40 bits are buffered.
        do_reset();
        pos = 0;
        for (int i = 0; i < 40 && mq.size() != 40; i++) begin
            drive32(1'b1, stream_word(pos, 0), 1'b0);
            pos += 32;
        end
        check("mid_fill_reached", 64'(mq.size()), 64'd40);
        do_reset();
        want_aligned = 1'b1;
        pos = 0;
        for (int i = 0; i < 12; i++) begin
            drive32(1'b1, stream_word(pos, 0), 1'b0);
            pos += 32;
        end
        check("restart_first_word", 64'(first_word), 64'd3);

        // Random traffic with occasional slips and gaps.
        do_reset();
        for (int i = 0; i < 250; i++) begin
            drive32($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0);
        end

        // Slip counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive32(1'b1, $urandom, 1'b1);
        end
        check("slip_sat", 64'(cnt32), CNT_EN ? 64'd255 : 64'd0);

        // 64-bit, bit-reversed instance: 33 words carry exactly 32 blocks.
        do_reset();
        pos = 0;
        for (int n = 1; n <= 33; n++) begin
            for (int i = 0; i < 64; i++) w64[63-i] = sbit(pos + i, 0);
            din64 = w64;
            vin64 = 1'b1;
            pos += 64;
            @(posedge clk);
            #1;
            n_prev = (64 * (n - 1)) / 66;
            n_cur  = (64 * n) / 66;
            exp_v  = (n_cur != n_prev);
            $display("txn w64 word=%0d -> valid=%0b hdr=%b data=%h", n, valid64, hdr64, data64);
            check("w64_valid", 64'(valid64), 64'(exp_v));
            if (exp_v) begin
                strobes++;
                check("w64_hdr", 64'(hdr64), 64'(HDR_PAT));
                check("w64_data", data64, DATA_PAT);
            end
            check("w64_slip_count", 64'(cnt64), 64'd0);
        end
        vin64 = 1'b0;
        check("w64_strobes", 64'(strobes), 64'd32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
